// File: rtl/display_source_scheduler.sv
// Time-shares one 4-digit display among five 16-bit sources.
// Sources are picked by hand, or rotated automatically with a dwell timer, a blanking gap and skipping of invalid sources.
module display_source_scheduler #(
    parameter int unsigned DWELL_CYCLES = 200_000_000,
    parameter int unsigned BLANK_CYCLES = 10_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        auto_en,
    input  logic [2:0]  man_sel,
    input  logic [15:0] src0,
    input  logic [15:0] src1,
    input  logic [15:0] src2,
    input  logic [15:0] src3,
    input  logic [15:0] src4,
    input  logic [4:0]  src_valid,
    output logic [15:0] value_out,
    output logic [2:0]  sel_out,
    output logic        blank,
    output logic        adv_pulse
);

    typedef enum logic [1:0] {
        ST_MANUAL,
        ST_SHOW,
        ST_BLANK
    } state_t;

    localparam logic [27:0] DWELL_LAST = 28'(DWELL_CYCLES - 1);
    localparam logic [27:0] BLANK_LAST = 28'(BLANK_CYCLES - 1);

    state_t      state, state_d;
    logic [27:0] cnt, cnt_d;
    logic [2:0]  sel_d;
    logic        blank_d;
    logic        adv_d;
    logic [15:0] value_d;
    logic [2:0]  man_clamp;
    logic [2:0]  nxt_valid;
    logic        found;
    logic [2:0]  idx;

    always_comb begin
        man_clamp = (man_sel > 3'd4) ? 3'd0 : man_sel;
    end

    // Scan sel+1 .. sel+5 (mod 5) so the current index is considered last.
    always_comb begin
        nxt_valid = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= 5; k++) begin
            idx = 3'((32'(sel_out) + k) % 5);
            if (!found && src_valid[idx]) begin
                found     = 1'b1;
                nxt_valid = idx;
            end
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        sel_d   = sel_out;
        blank_d = 1'b0;
        adv_d   = 1'b0;
        case (state)
            ST_MANUAL: begin
                cnt_d = '0;
                if (auto_en) begin
                    state_d = ST_SHOW;
                end else begin
                    sel_d = man_clamp;
                end
            end
            ST_SHOW: begin
                if (!auto_en) begin
                    state_d = ST_MANUAL;
                    cnt_d   = '0;
                    sel_d   = man_clamp;
                end else if (cnt == DWELL_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    blank_d = 1'b1;
                end else begin
                    cnt_d = cnt + 28'd1;
                end
            end
            ST_BLANK: begin
                if (!auto_en) begin
                    state_d = ST_MANUAL;
                    cnt_d   = '0;
                    sel_d   = man_clamp;
                end else if (cnt == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                    sel_d   = nxt_valid;
                    adv_d   = 1'b1;
                end else begin
                    cnt_d   = cnt + 28'd1;
                    blank_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_MANUAL;
                cnt_d   = '0;
            end
        endcase
    end

    // Output value is taken from the next selection so value_out and sel_out always agree.
    always_comb begin
        value_d = '0;
        if (!blank_d) begin
            case (sel_d)
                3'd1:    value_d = src1;
                3'd2:    value_d = src2;
                3'd3:    value_d = src3;
                3'd4:    value_d = src4;
                default: value_d = src0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_MANUAL;
            cnt       <= '0;
            sel_out   <= '0;
            blank     <= 1'b0;
            adv_pulse <= 1'b0;
            value_out <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            sel_out   <= sel_d;
            blank     <= blank_d;
            adv_pulse <= adv_d;
            value_out <= value_d;
        end
    end

endmodule

// File: tb/tb_display_source_scheduler.sv
// Directed self-checking bench for display_source_scheduler with short dwell/blank times.
module tb_display_source_scheduler;

    logic        clk;
    logic        reset;
    logic        auto_en;
    logic [2:0]  man_sel;
    logic [15:0] srcv [5];
    logic [4:0]  src_valid;
    logic [15:0] value_out;
    logic [2:0]  sel_out;
    logic        blank;
    logic        adv_pulse;

    int unsigned checks = 0;
    int unsigned errors = 0;

    display_source_scheduler #(
        .DWELL_CYCLES(8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .auto_en   (auto_en),
        .man_sel   (man_sel),
        .src0      (srcv[0]),
        .src1      (srcv[1]),
        .src2      (srcv[2]),
        .src3      (srcv[3]),
        .src4      (srcv[4]),
        .src_valid (src_valid),
        .value_out (value_out),
        .sel_out   (sel_out),
        .blank     (blank),
        .adv_pulse (adv_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (errors=%0d)", errors);
        $fatal(1);
    end

    // Watches one full source slot from its first shown cycle: 8 shown, then 2 blanked.
    task automatic run_slot(input logic [2:0] exp_sel, input logic exp_adv_first);
        for (int i = 0; i < 10; i++) begin
            logic        exp_blank;
            logic        exp_adv;
            logic [15:0] exp_val;
            @(negedge clk);
            exp_blank = (i >= 8);
            exp_adv   = (i == 0) ? exp_adv_first : 1'b0;
            exp_val   = exp_blank ? 16'h0000 : srcv[exp_sel];
            checks++;
            if (sel_out !== exp_sel) begin
                errors++;
                $display("FAIL slot_sel cyc=%0d: got %0d expected %0d", i, sel_out, exp_sel);
            end
            checks++;
            if (blank !== exp_blank) begin
                errors++;
                $display("FAIL slot_blank sel=%0d cyc=%0d: got %b expected %b", exp_sel, i, blank, exp_blank);
            end
            checks++;
            if (adv_pulse !== exp_adv) begin
                errors++;
                $display("FAIL slot_adv sel=%0d cyc=%0d: got %b expected %b", exp_sel, i, adv_pulse, exp_adv);
            end
            checks++;
            if (value_out !== exp_val) begin
                errors++;
                $display("FAIL slot_value sel=%0d cyc=%0d: got %h expected %h", exp_sel, i, value_out, exp_val);
            end
        end
    endtask

    task automatic go_manual(input logic [2:0] ms);
        @(negedge clk);
        auto_en = 1'b0;
        man_sel = ms;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        auto_en   = 1'b0;
        man_sel   = 3'd3;
        src_valid = 5'b00000;
        srcv[0] = 16'hA0A0; srcv[1] = 16'hB1B1; srcv[2] = 16'hC2C2;
        srcv[3] = 16'h1234; srcv[4] = 16'hE4E4;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({value_out, sel_out, blank, adv_pulse} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got val=%h sel=%0d blank=%b adv=%b expected all zero",
                     value_out, sel_out, blank, adv_pulse);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (value_out !== 16'h1234) begin
            errors++;
            $display("FAIL manual3_value: got %h expected 1234", value_out);
        end
        checks++;
        if (sel_out !== 3'd3 || blank !== 1'b0) begin
            errors++;
            $display("FAIL manual3_sel: got sel=%0d blank=%b expected sel=3 blank=0", sel_out, blank);
        end
    endtask

    task automatic test_manual();
        man_sel = 3'd6;
        @(negedge clk);
        checks++;
        if (sel_out !== 3'd0 || value_out !== 16'hA0A0) begin
            errors++;
            $display("FAIL clamp6: got sel=%0d val=%h expected sel=0 val=a0a0", sel_out, value_out);
        end
        src_valid = 5'b00000;
        man_sel   = 3'd4;
        @(negedge clk);
        checks++;
        if (sel_out !== 3'd4 || value_out !== 16'hE4E4) begin
            errors++;
            $display("FAIL manual4_invalid: got sel=%0d val=%h expected sel=4 val=e4e4", sel_out, value_out);
        end
        srcv[4] = 16'h4321;
        @(negedge clk);
        checks++;
        if (value_out !== 16'h4321) begin
            errors++;
            $display("FAIL src_follow: got %h expected 4321", value_out);
        end
        srcv[4] = 16'hE4E4;
        @(negedge clk);
    endtask

    task automatic test_auto_rotate();
        go_manual(3'd0);
        src_valid = 5'b11111;
        auto_en   = 1'b1;
        run_slot(3'd0, 1'b0);
        run_slot(3'd1, 1'b1);
        run_slot(3'd2, 1'b1);
        run_slot(3'd3, 1'b1);
        run_slot(3'd4, 1'b1);
        run_slot(3'd0, 1'b1);
    endtask

    task automatic test_skip_invalid();
        go_manual(3'd1);
        src_valid = 5'b10010;
        auto_en   = 1'b1;
        run_slot(3'd1, 1'b0);
        run_slot(3'd4, 1'b1);
        run_slot(3'd1, 1'b1);
    endtask

    task automatic test_none_valid();
        go_manual(3'd2);
        src_valid = 5'b00000;
        auto_en   = 1'b1;
        run_slot(3'd2, 1'b0);
        run_slot(3'd0, 1'b1);
    endtask

    task automatic test_drop_and_reset();
        go_manual(3'd3);
        src_valid = 5'b11111;
        auto_en   = 1'b1;
        repeat (9) @(negedge clk);
        checks++;
        if (blank !== 1'b1) begin
            errors++;
            $display("FAIL in_blank: got %b expected 1", blank);
        end
        auto_en = 1'b0;
        man_sel = 3'd7;
        @(negedge clk);
        checks++;
        if (blank !== 1'b0 || sel_out !== 3'd0 || value_out !== 16'hA0A0 || adv_pulse !== 1'b0) begin
            errors++;
            $display("FAIL drop_in_blank: got blank=%b sel=%0d val=%h adv=%b expected 0 0 a0a0 0",
                     blank, sel_out, value_out, adv_pulse);
        end
        man_sel = 3'd2;
        @(negedge clk);
        auto_en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (sel_out !== 3'd2 || value_out !== 16'hC2C2) begin
            errors++;
            $display("FAIL mid_show: got sel=%0d val=%h expected 2 c2c2", sel_out, value_out);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({value_out, sel_out, blank, adv_pulse} !== 21'd0) begin
            errors++;
            $display("FAIL reset_mid_show: got val=%h sel=%0d blank=%b adv=%b expected all zero",
                     value_out, sel_out, blank, adv_pulse);
        end
        reset   = 1'b0;
        auto_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_manual();
        test_auto_rotate();
        test_skip_invalid();
        test_none_valid();
        test_drop_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
